// File: rtl/if_id_queue.sv
// Fetch-to-decode skid queue: a circular buffer of {pc, instr, inv_addr}
// entries with a RUN/FAULT state. Accepting an entry flagged as an invalid
// address freezes intake (FAULT) until a flush; queued entries still drain
// to decode so the faulting instruction reaches the trap logic.
module if_id_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_inv_addr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_inv_addr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 64 + 32 + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;

    logic [EW-1:0]    mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [0:0]       state_reg, state_next;
    logic             push, pop;
    logic [DEPTH-1:0] slot_we;
    logic [EW-1:0]    head;

    // Handshakes. Flush blocks both sides; a full queue never passes through.
    assign in_ready  = (count_reg < CW'(DEPTH)) && (state_reg == RUN) && !flush;
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Per-slot write enable decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Next-state for pointers, occupancy and RUN/FAULT; flush wins over all.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        state_next  = state_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            state_next  = RUN;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
            if (push && in_inv_addr) begin
                state_next = FAULT;
            end
        end
    end

    // Control registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= RUN;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            state_reg  <= state_next;
        end
    end

    // Entry storage; reset zeroes slots so the head reads 0 out of reset,
    // while flush leaves payloads untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    mem_reg[i] <= {in_pc, in_instr, in_inv_addr};
                end
            end
        end
    end

    // Head slot presented combinationally to decode.
    assign head         = mem_reg[rd_ptr_reg];
    assign out_pc       = head[EW-1 -: 64];
    assign out_instr    = head[32:1];
    assign out_inv_addr = head[0];
    assign count        = count_reg;
    assign fault        = (state_reg == FAULT);

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios plus a randomized run,
// checked against a queue-based behavioural model.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [63:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          in_inv_addr = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_inv_addr, fault;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_inv_addr(in_inv_addr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_inv_addr(out_inv_addr), .out_ready(out_ready),
        .count(count), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        inv;
    } ent_t;

    ent_t q[$];
    bit   mfault = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain FIFO semantics plus a sticky fault bit.
    function automatic bit m_in_ready();
        return (q.size() < DEPTH) && !mfault && !flush;
    endfunction

    function automatic void step_model();
        bit   push_m, pop_m;
        ent_t e;
        if (!rst_n || flush) begin
            q.delete();
            mfault = 1'b0;
            return;
        end
        push_m = in_valid && m_in_ready();
        pop_m  = (q.size() != 0) && out_ready;
        if (pop_m) void'(q.pop_front());
        if (push_m) begin
            e = '{pc: in_pc, instr: in_instr, inv: in_inv_addr};
            q.push_back(e);
            if (in_inv_addr) mfault = 1'b1;
        end
    endfunction

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic v, input logic [63:0] pc,
                         input logic [31:0] ins, input logic inv, input logic ordy);
        flush = f; in_valid = v; in_pc = pc; in_instr = ins;
        in_inv_addr = inv; out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        n_vec++; if (out_inv_addr !== 1'b0) begin n_err++; $display("FAIL reset_out_inv: got %b want 0", out_inv_addr); end
        n_vec++; if (count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        q.delete(); mfault = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_push();
        drive(0, 1, 64'h0, 32'h0050_0093, 0, 0);
        tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_vec++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL single_pc: got %h want 0", out_pc); end
        n_vec++; if (out_instr !== 32'h0050_0093) begin n_err++; $display("FAIL single_instr: got %h want 00500093", out_instr); end
        n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        drive(0, 0, 64'h0, 32'h0, 0, 1);
        tick();
        n_vec++; if (count !== CW'(0)) begin n_err++; $display("FAIL single_drain: got %0d want 0", count); end
    endtask

    task automatic test_full();
        drive(0, 1, 64'h0, 32'h11, 0, 0); tick();
        drive(0, 1, 64'h4, 32'h22, 0, 0); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL full_count: got %0d want 2", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        drive(0, 1, 64'h8, 32'h33, 0, 1);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_no_passthru: got %b want 0", in_ready); end
        tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL full_pop_count: got %0d want 1", count); end
        n_vec++; if (out_pc !== 64'h4) begin n_err++; $display("FAIL full_pop_head: got %h want 4", out_pc); end
    endtask

    // Entry state: one entry queued (pc 0x4). Seven push+pop cycles wrap pointers.
    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 64'h8 + 64'(4 * k), 32'h100 + 32'(k), 0, 1);
            tick();
            drive(0, 0, 64'h0, 32'h0, 0, 0);
            n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 1", k, count); end
            n_vec++; if (out_pc !== 64'h8 + 64'(4 * k)) begin n_err++; $display("FAIL b2b_head[%0d]: got %h want %h", k, out_pc, 64'h8 + 64'(4 * k)); end
        end
        drive(1, 0, 64'h0, 32'h0, 0, 0); tick();
    endtask

    task automatic test_fault();
        drive(0, 1, 64'h1002, 32'hDEAD_BEEF, 1, 0); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_set: got %b want 1", fault); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fault_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_inv_addr !== 1'b1) begin n_err++; $display("FAIL fault_head_inv: got %b want 1", out_inv_addr); end
        n_vec++; if (out_instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fault_head_instr: got %h want deadbeef", out_instr); end
        drive(0, 1, 64'h2000, 32'h55, 0, 1); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (count !== CW'(0)) begin n_err++; $display("FAIL fault_drain: got %0d want 0", count); end
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky: got %b want 1", fault); end
        drive(1, 0, 64'h0, 32'h0, 0, 0); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", fault); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fault_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush_full();
        drive(0, 1, 64'h40, 32'hA, 0, 0); tick();
        drive(0, 1, 64'h44, 32'hB, 0, 0); tick();
        drive(1, 1, 64'h48, 32'hC, 0, 1); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (count !== CW'(0)) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        drive(0, 1, 64'h4C, 32'hD, 0, 0); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        n_vec++; if (out_pc !== 64'h4C) begin n_err++; $display("FAIL flush_restart_head: got %h want 4c", out_pc); end
        drive(1, 0, 64'h0, 32'h0, 0, 0); tick();
    endtask

    task automatic test_async_reset();
        drive(0, 1, 64'h80, 32'hE, 0, 0); tick();
        drive(0, 1, 64'h84, 32'hF, 0, 0); tick();
        drive(0, 0, 64'h0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        n_vec++; if (count !== CW'(0)) begin n_err++; $display("FAIL areset_count: got %0d want 0", count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL areset_pc: got %h want 0", out_pc); end
        q.delete(); mfault = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        ent_t h;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                  {$urandom, $urandom}, $urandom,
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 1));
            n_vec++; if (in_ready !== m_in_ready()) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, m_in_ready()); end
            n_vec++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, q.size() != 0); end
            n_vec++; if (count !== CW'(q.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, q.size()); end
            n_vec++; if (fault !== mfault) begin n_err++; $display("FAIL rnd_fault[%0d]: got %b want %b", c, fault, mfault); end
            if (q.size() != 0) begin
                h = q[0];
                n_vec++; if ({out_pc, out_instr, out_inv_addr} !== {h.pc, h.instr, h.inv}) begin
                    n_err++; $display("FAIL rnd_head[%0d]: got %h/%h/%b want %h/%h/%b", c, out_pc, out_instr, out_inv_addr, h.pc, h.instr, h.inv);
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_fault();
        test_flush_full();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
